// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between a fetch requester (IF) and
// a load/store requester (D). At most one memory transaction is outstanding.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate the winner when both
// requesters are valid. Without it, D always wins over IF.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_W-1:0]     if_addr,
  input  logic                  if_flush,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,

  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,

  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,

  output logic                  busy
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_owner_d;   // 1: current transaction belongs to D
  logic                r_drop;      // fetch response must be discarded
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [STRB_W-1:0]   r_mem_wstrb;
  logic                r_if_rvalid;
  logic [DATA_W-1:0]   r_if_rdata;
  logic                r_d_rvalid;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_busy;

  logic                w_grant_if;
  logic                w_grant_d;
  logic                w_accept;
  logic                w_hs_if;
  logic                w_hs_d;
  logic                w_if_flush_hit;

`ifdef ARB_ROUND_ROBIN_EN
  logic                r_last_d;    // 1: last handshake was D, 0: IF

  // Arbitration: on contention the requester that did not win last goes first
  always_comb begin
    w_grant_if = 1'b0;
    w_grant_d  = 1'b0;
    if (if_req_valid && d_req_valid) begin
      if (r_last_d) begin
        w_grant_if = 1'b1;
      end else begin
        w_grant_d  = 1'b1;
      end
    end else begin
      w_grant_if = if_req_valid;
      w_grant_d  = d_req_valid;
    end
  end

  // Remember the owner of every accepted request
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last_d <= 1'b0;
    end else if (w_hs_d) begin
      r_last_d <= 1'b1;
    end else if (w_hs_if) begin
      r_last_d <= 1'b0;
    end
  end
`else
  // Arbitration: fixed priority, D ahead of IF
  always_comb begin
    w_grant_d  = d_req_valid;
    w_grant_if = if_req_valid & ~d_req_valid;
  end
`endif

  // Ready only in IDLE and never while reset is asserted
  always_comb begin
    w_accept       = reset & (r_state == ST_IDLE);
    if_req_ready   = w_accept & w_grant_if;
    d_req_ready    = w_accept & w_grant_d;
    w_hs_if        = if_req_valid & if_req_ready;
    w_hs_d         = d_req_valid & d_req_ready;
    w_if_flush_hit = if_flush & ~r_owner_d;
  end

  // Transaction FSM with registered memory-port and response outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_owner_d   <= 1'b0;
      r_drop      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_hs_d) begin
            r_state     <= ST_REQ;
            r_owner_d   <= 1'b1;
            r_mem_req   <= 1'b1;
            r_mem_we    <= d_we;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            r_mem_wstrb <= d_wstrb;
            r_busy      <= 1'b1;
          end else if (w_hs_if) begin
            r_state     <= ST_REQ;
            r_owner_d   <= 1'b0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_busy      <= 1'b1;
          end
        end
        ST_REQ: begin
          if (w_if_flush_hit) begin
            r_drop <= 1'b1;
          end
          if (mem_gnt) begin
            r_state   <= ST_RESP;
            r_mem_req <= 1'b0;
          end
        end
        ST_RESP: begin
          if (mem_rvalid) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_drop  <= 1'b0;
            if (r_owner_d) begin
              r_d_rvalid <= 1'b1;
              r_d_rdata  <= mem_rdata;
            end else if (!(r_drop || if_flush)) begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= mem_rdata;
            end
          end else if (w_if_flush_hit) begin
            r_drop <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
          r_drop    <= 1'b0;
        end
      endcase
    end
  end

  // Output mapping
  always_comb begin
    mem_req   = r_mem_req;
    mem_we    = r_mem_we;
    mem_addr  = r_mem_addr;
    mem_wdata = r_mem_wdata;
    mem_wstrb = r_mem_wstrb;
    if_rvalid = r_if_rvalid;
    if_rdata  = r_if_rdata;
    d_rvalid  = r_d_rvalid;
    d_rdata   = r_d_rdata;
    busy      = r_busy;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed table-driven bench for mem_port_arbiter (32-bit address/data).
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the
// falling edge.
module tb_mem_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req_valid = 1'b0, if_req_ready, if_flush = 1'b0, if_rvalid;
  logic [31:0] if_addr = '0, if_rdata;
  logic        d_req_valid = 1'b0, d_req_ready, d_we = 1'b0, d_rvalid;
  logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
  logic [3:0]  d_wstrb = '0;
  logic        mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_wstrb;
  logic        busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_flush(if_flush), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct {
    logic rst; logic ifv; logic [31:0] ifa; logic fl;
    logic dv; logic dwe; logic [31:0] da; logic [31:0] dwd; logic [3:0] dws;
    logic gnt; logic mrv; logic [31:0] mrd;
    logic e_ifr; logic e_dr; logic e_mreq; logic e_busy; logic e_ifrv; logic e_drv;
    logic [31:0] e_rd;
    logic cm; logic e_we; logic [31:0] e_ma; logic [31:0] e_mwd; logic [3:0] e_mws;
  } vec_t;

  vec_t cur;
  vec_t vq[$];
  int   n_vec = 0;
  int   n_fail = 0;

  // Stage the inputs of the next row
  function automatic void in_v(logic rst, logic ifv, logic [31:0] ifa, logic fl,
                               logic dv, logic dwe, logic [31:0] da, logic [31:0] dwd,
                               logic [3:0] dws, logic gnt, logic mrv, logic [31:0] mrd);
    cur.rst = rst; cur.ifv = ifv; cur.ifa = ifa; cur.fl = fl;
    cur.dv = dv; cur.dwe = dwe; cur.da = da; cur.dwd = dwd; cur.dws = dws;
    cur.gnt = gnt; cur.mrv = mrv; cur.mrd = mrd;
  endfunction

  // Add expectations to the staged inputs and push the row
  function automatic void ex_v(logic ifr, logic dr, logic mreq, logic bsy,
                               logic ifrv, logic drv, logic [31:0] rd);
    cur.e_ifr = ifr; cur.e_dr = dr; cur.e_mreq = mreq; cur.e_busy = bsy;
    cur.e_ifrv = ifrv; cur.e_drv = drv; cur.e_rd = rd;
    cur.cm = 1'b0; cur.e_we = 1'b0; cur.e_ma = '0; cur.e_mwd = '0; cur.e_mws = '0;
    vq.push_back(cur);
  endfunction

  // Also check the memory-port payload on the last pushed row
  function automatic void mem_v(logic we, logic [31:0] ma, logic [31:0] mwd, logic [3:0] mws);
    vec_t t;
    t = vq.pop_back();
    t.cm = 1'b1; t.e_we = we; t.e_ma = ma; t.e_mwd = mwd; t.e_mws = mws;
    vq.push_back(t);
  endfunction

  function automatic void idle_in();
    in_v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction

  task automatic drive(input vec_t v);
    reset = v.rst; if_req_valid = v.ifv; if_addr = v.ifa; if_flush = v.fl;
    d_req_valid = v.dv; d_we = v.dwe; d_addr = v.da; d_wdata = v.dwd; d_wstrb = v.dws;
    mem_gnt = v.gnt; mem_rvalid = v.mrv; mem_rdata = v.mrd;
  endtask

  task automatic check_row(input int idx, input vec_t v);
    logic [5:0]  ctl_a, ctl_e;
    logic [31:0] rd_a, rd_e;
    logic [68:0] m_a, m_e;
    ctl_a = {if_req_ready, d_req_ready, mem_req, busy, if_rvalid, d_rvalid};
    ctl_e = {v.e_ifr, v.e_dr, v.e_mreq, v.e_busy, v.e_ifrv, v.e_drv};
    rd_a = v.e_ifrv ? if_rdata : (v.e_drv ? d_rdata : 32'h0);
    rd_e = (v.e_ifrv || v.e_drv) ? v.e_rd : 32'h0;
    m_a  = v.cm ? {mem_we, mem_addr, mem_wdata, mem_wstrb} : 69'h0;
    m_e  = v.cm ? {v.e_we, v.e_ma, v.e_mwd, v.e_mws} : 69'h0;
    n_vec++;
    if ((ctl_a !== ctl_e) || (rd_a !== rd_e) || (m_a !== m_e)) begin
      n_fail++;
      $display("FAIL row%0d ctl(ifr,dr,mreq,busy,ifrv,drv) actual=%b required=%b rdata actual=%h required=%h mem actual=%h required=%h",
               idx, ctl_a, ctl_e, rd_a, rd_e, m_a, m_e);
    end
  endtask

  // D load with programmable grant and response delays
  task automatic do_load(input logic [31:0] addr, input logic [31:0] data,
                         input int gnt_dly, input int rsp_dly);
    @(posedge clk); #1;
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = addr; d_wstrb = 4'h0;
    @(negedge clk); chk("load_ready", 32'(d_req_ready), 32'h1);
    for (int k = 0; k <= gnt_dly; k++) begin
      @(posedge clk); #1;
      d_req_valid = 1'b0; d_addr = '0;
      mem_gnt = (k == gnt_dly);
      @(negedge clk);
      chk("load_mem_req", 32'(mem_req), 32'h1);
      chk("load_mem_addr", mem_addr, addr);
    end
    for (int k = 0; k <= rsp_dly; k++) begin
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      mem_rvalid = (k == rsp_dly); mem_rdata = data;
      @(negedge clk);
      chk("load_wait", 32'({mem_req, busy, d_rvalid}), 32'b010);
    end
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    chk("load_rvalid", 32'({d_rvalid, if_rvalid, busy}), 32'b100);
    chk("load_rdata", d_rdata, data);
    @(posedge clk); #1;
    @(negedge clk);
    chk("load_pulse_end", 32'(d_rvalid), 32'h0);
  endtask

  initial begin
    logic wd_prev;
    logic wd;

    // Reset, readys gated while reset is low
    in_v(0, 1, 32'h4, 0, 1, 0, 32'h8, 0, 0, 0, 0, 0); ex_v(0,0,0,0,0,0,0); mem_v(0, 0, 0, 0);
    // Single fetch, immediate grant and response
    in_v(1, 1, 32'h4, 0, 0, 0, 0, 0, 0, 0, 0, 0);     ex_v(1,0,0,0,0,0,0);
    in_v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);         ex_v(0,0,1,1,0,0,0); mem_v(0, 32'h4, 0, 0);
    in_v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h13);    ex_v(0,0,0,1,0,0,0);
    idle_in();                                        ex_v(0,0,0,0,1,0,32'h13);
    in_v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h77);    ex_v(0,0,0,0,0,0,0);
    idle_in();                                        ex_v(0,0,0,0,0,0,0);
    // Store with 3-cycle grant delay; stray mem_rvalid in REQ; flush while D owns
    in_v(1, 0, 0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0); ex_v(0,1,0,0,0,0,0);
    in_v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99);    ex_v(0,0,1,1,0,0,0); mem_v(1, 32'h100, 32'hDEADBEEF, 4'hF);
    idle_in();                                        ex_v(0,0,1,1,0,0,0); mem_v(1, 32'h100, 32'hDEADBEEF, 4'hF);
    idle_in();                                        ex_v(0,0,1,1,0,0,0); mem_v(1, 32'h100, 32'hDEADBEEF, 4'hF);
    in_v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);         ex_v(0,0,1,1,0,0,0); mem_v(1, 32'h100, 32'hDEADBEEF, 4'hF);
    in_v(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);         ex_v(0,0,0,1,0,0,0);
    in_v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55);    ex_v(0,0,0,1,0,0,0);
    idle_in();                                        ex_v(0,0,0,0,0,1,32'h55);
    idle_in();                                        ex_v(0,0,0,0,0,0,0);
    // Fetch flushed in RESP, then a fetch accepted alongside an IDLE flush
    in_v(1, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0);   ex_v(1,0,0,0,0,0,0);
    in_v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);         ex_v(0,0,1,1,0,0,0);
    in_v(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);         ex_v(0,0,0,1,0,0,0);
    in_v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA5555); ex_v(0,0,0,1,0,0,0);
    in_v(1, 1, 32'h204, 1, 0, 0, 0, 0, 0, 0, 0, 0);   ex_v(1,0,0,0,0,0,0);
    in_v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);         ex_v(0,0,1,1,0,0,0); mem_v(0, 32'h204, 0, 0);
    in_v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234);  ex_v(0,0,0,1,0,0,0);
    idle_in();                                        ex_v(0,0,0,0,1,0,32'h1234);
    // Reset in RESP, late mem_rvalid afterwards
    in_v(1, 1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0);   ex_v(1,0,0,0,0,0,0);
    in_v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);         ex_v(0,0,1,1,0,0,0);
    in_v(0, 1, 32'h300, 0, 1, 0, 32'h8, 0, 0, 0, 0, 0); ex_v(0,0,0,1,0,0,0);
    in_v(0, 1, 32'h300, 0, 1, 0, 32'h8, 0, 0, 0, 0, 0); ex_v(0,0,0,0,0,0,0); mem_v(0, 0, 0, 0);
    in_v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD);   ex_v(0,0,0,0,0,0,0);
    idle_in();                                        ex_v(0,0,0,0,0,0,0);
    // Back-to-back fetches: second handshake with the first rvalid
    in_v(1, 1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0);    ex_v(1,0,0,0,0,0,0);
    in_v(1, 1, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0, 0);    ex_v(0,0,1,1,0,0,0); mem_v(0, 32'h10, 0, 0);
    in_v(1, 1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA1); ex_v(0,0,0,1,0,0,0);
    in_v(1, 1, 32'h14, 0, 0, 0, 0, 0, 0, 0, 0, 0);    ex_v(1,0,0,0,1,0,32'hA1);
    in_v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);         ex_v(0,0,1,1,0,0,0); mem_v(0, 32'h14, 0, 0);
    in_v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA2);    ex_v(0,0,0,1,0,0,0);
    idle_in();                                        ex_v(0,0,0,0,1,0,32'hA2);
    // Both requesters valid for four grants; last handshake above was IF
    wd_prev = 1'b0;
    for (int g = 0; g < 4; g++) begin
      wd = RR ? ((g % 2) == 0) : 1'b1;
      in_v(1, 1, 32'h500, 0, 1, 0, 32'h400, 0, 0, 0, 0, 0);
      ex_v(!wd, wd, 0, 0, (g > 0) && !wd_prev, (g > 0) && wd_prev, 32'(g));
      in_v(1, 1, 32'h500, 0, 1, 0, 32'h400, 0, 0, 1, 0, 0);
      ex_v(0, 0, 1, 1, 0, 0, 0); mem_v(0, wd ? 32'h400 : 32'h500, 0, 0);
      in_v(1, 1, 32'h500, 0, 1, 0, 32'h400, 0, 0, 0, 1, 32'(g + 1));
      ex_v(0, 0, 0, 1, 0, 0, 0);
      wd_prev = wd;
    end
    idle_in(); ex_v(0, 0, 0, 0, !wd_prev, wd_prev, 32'h4);

    // Two cycles of reset before the table
    reset = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      drive(vq[i]);
      @(negedge clk);
      check_row(i, vq[i]);
    end

    // Loads with stretched grant/response timing
    @(posedge clk); #1;
    idle_in(); drive(cur);
    do_load(32'h600, 32'hCAFEF00D, 2, 3);
    do_load(32'h604, 32'h0BADC0DE, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
